// File: rtl/riscv_core_mc.sv
// rtl/riscv_core_mc.sv - multi-cycle RV32I core with req/rvalid fetch and data ports
// Optional feature macro: RISCV_SUBWORD_EN (byte/halfword loads and stores)
module riscv_core_mc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_data_i,
  output logic        data_req_o,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_we_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        retire_o,
  output logic        halt_o,
  output logic        trap_o,
  output logic [31:0] dbg_pc_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP} state_t;

  state_t      state, next_state;
  logic [31:0] pc, ir, rs1_q, rs2_q, res_q;
  logic [31:0] rf [32];

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd_idx, rs1_idx, rs2_idx;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc_plus4;

  assign opcode   = ir[6:0];
  assign rd_idx   = ir[11:7];
  assign funct3   = ir[14:12];
  assign rs1_idx  = ir[19:15];
  assign rs2_idx  = ir[24:20];
  assign funct7   = ir[31:25];
  assign imm_i    = {{20{ir[31]}}, ir[31:20]};
  assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u    = {ir[31:12], 12'b0};
  assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign pc_plus4 = pc + 32'd4;

  logic load_f3_ok, store_f3_ok;
`ifdef RISCV_SUBWORD_EN
  assign load_f3_ok  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign store_f3_ok = funct3 inside {3'b000, 3'b001, 3'b010};
`else
  assign load_f3_ok  = (funct3 == 3'b010);
  assign store_f3_ok = (funct3 == 3'b010);
`endif

  // Decode legality: opcode/funct combinations and register indices beyond NUM_REGS
  logic illegal, uses_rs1, uses_rs2, uses_rd, is_system;
  always_comb begin
    illegal   = 1'b0;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    uses_rd   = 1'b1;
    is_system = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: uses_rs1 = 1'b0;
      OP_JALR: illegal = (funct3 != 3'b000);
      OP_BRANCH: begin
        uses_rs2 = 1'b1;
        uses_rd  = 1'b0;
        illegal  = (funct3[2:1] == 2'b01);
      end
      OP_LOAD: illegal = !load_f3_ok;
      OP_STORE: begin
        uses_rs2 = 1'b1;
        uses_rd  = 1'b0;
        illegal  = !store_f3_ok;
      end
      OP_IMM: begin
        if (funct3 == 3'b001)
          illegal = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OP_REG: begin
        uses_rs2 = 1'b1;
        illegal  = !((funct7 == 7'b0000000) ||
                     ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OP_FENCE: begin
        uses_rs1 = 1'b0;
        uses_rd  = 1'b0;
        illegal  = (funct3 != 3'b000);
      end
      OP_SYSTEM: begin
        uses_rs1  = 1'b0;
        uses_rd   = 1'b0;
        is_system = 1'b1;
        illegal   = !((ir == 32'h0000_0073) || (ir == 32'h0010_0073));
      end
      default: illegal = 1'b1;
    endcase
    if (uses_rs1 && ({1'b0, rs1_idx} >= REG_LIMIT)) illegal = 1'b1;
    if (uses_rs2 && ({1'b0, rs2_idx} >= REG_LIMIT)) illegal = 1'b1;
    if (uses_rd  && ({1'b0, rd_idx}  >= REG_LIMIT)) illegal = 1'b1;
  end

  // Execute: ALU, branch compare, control-flow target and memory address
  logic [31:0] op_b, alu, target, mem_addr, exec_res;
  logic [4:0]  shamt;
  logic        taken, redirect, misalign, exec_trap, is_mem;
  always_comb begin
    op_b  = ((opcode == OP_REG) || (opcode == OP_BRANCH)) ? rs2_q : imm_i;
    shamt = op_b[4:0];
    case (funct3)
      3'b000:  alu = ((opcode == OP_REG) && funct7[5]) ? rs1_q - op_b : rs1_q + op_b;
      3'b001:  alu = rs1_q << shamt;
      3'b010:  alu = {31'b0, $signed(rs1_q) < $signed(op_b)};
      3'b011:  alu = {31'b0, rs1_q < op_b};
      3'b100:  alu = rs1_q ^ op_b;
      3'b101:  alu = funct7[5] ? 32'($signed(rs1_q) >>> shamt) : rs1_q >> shamt;
      3'b110:  alu = rs1_q | op_b;
      default: alu = rs1_q & op_b;
    endcase
    case (funct3)
      3'b000:  taken = (rs1_q == rs2_q);
      3'b001:  taken = (rs1_q != rs2_q);
      3'b100:  taken = ($signed(rs1_q) < $signed(rs2_q));
      3'b101:  taken = !($signed(rs1_q) < $signed(rs2_q));
      3'b110:  taken = (rs1_q < rs2_q);
      default: taken = !(rs1_q < rs2_q);
    endcase
    case (opcode)
      OP_JAL:  target = pc + imm_j;
      OP_JALR: target = (rs1_q + imm_i) & ~32'd1;
      default: target = pc + imm_b;
    endcase
    redirect = (opcode == OP_JAL) || (opcode == OP_JALR) || ((opcode == OP_BRANCH) && taken);
    is_mem   = (opcode == OP_LOAD) || (opcode == OP_STORE);
    mem_addr = rs1_q + ((opcode == OP_STORE) ? imm_s : imm_i);
`ifdef RISCV_SUBWORD_EN
    case (funct3[1:0])
      2'b10:   misalign = (mem_addr[1:0] != 2'b00);
      2'b01:   misalign = mem_addr[0];
      default: misalign = 1'b0;
    endcase
`else
    misalign = (mem_addr[1:0] != 2'b00);
`endif
    exec_trap = (redirect && target[1]) || (is_mem && misalign);
    case (opcode)
      OP_LUI:            exec_res = imm_u;
      OP_AUIPC:          exec_res = pc + imm_u;
      OP_JAL, OP_JALR:   exec_res = pc_plus4;
      OP_LOAD, OP_STORE: exec_res = mem_addr;
      default:           exec_res = alu;
    endcase
  end

  // Store lane steering and load lane extraction
  logic [3:0]  st_we;
  logic [31:0] st_wdata, ld_val;
`ifdef RISCV_SUBWORD_EN
  logic [4:0]  lane_sh;
  logic [31:0] ld_shift;
`endif
  always_comb begin
    st_we    = 4'hF;
    st_wdata = rs2_q;
    ld_val   = data_rdata_i;
`ifdef RISCV_SUBWORD_EN
    lane_sh  = {res_q[1:0], 3'b000};
    ld_shift = data_rdata_i >> lane_sh;
    case (funct3[1:0])
      2'b00: begin
        st_we    = 4'b0001 << res_q[1:0];
        st_wdata = rs2_q << lane_sh;
      end
      2'b01: begin
        st_we    = 4'b0011 << res_q[1:0];
        st_wdata = rs2_q << lane_sh;
      end
      default: ;
    endcase
    case (funct3)
      3'b000:  ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_val = {24'b0, ld_shift[7:0]};
      3'b101:  ld_val = {16'b0, ld_shift[15:0]};
      default: ld_val = data_rdata_i;
    endcase
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= next_state;
  end

  // Next-state and handshake/retire decode
  logic instr_req, data_req, retire;
  always_comb begin
    next_state = state;
    instr_req  = 1'b0;
    data_req   = 1'b0;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_rvalid_i) next_state = S_DECODE;
      end
      S_DECODE: begin
        if (illegal) next_state = S_TRAP;
        else if (is_system) begin
          next_state = S_HALT;
          retire     = 1'b1;
        end else next_state = S_EXEC;
      end
      S_EXEC: begin
        if (exec_trap) next_state = S_TRAP;
        else if (is_mem) next_state = S_MEM;
        else if ((opcode == OP_BRANCH) || (opcode == OP_FENCE)) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end else next_state = S_WB;
      end
      S_MEM: begin
        data_req = 1'b1;
        if (data_rvalid_i) begin
          if (opcode == OP_STORE) begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end else next_state = S_WB;
        end
      end
      S_WB: begin
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = state;
    endcase
  end

  // Datapath registers: IR, operands, result, PC and register file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= RESET_PC;
      ir    <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      res_q <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH:  if (instr_rvalid_i) ir <= instr_data_i;
        S_DECODE: begin
          rs1_q <= rf[rs1_idx];
          rs2_q <= rf[rs2_idx];
        end
        S_EXEC: begin
          if (!exec_trap) begin
            res_q <= exec_res;
            if ((opcode == OP_JAL) || (opcode == OP_JALR) ||
                (opcode == OP_BRANCH) || (opcode == OP_FENCE))
              pc <= redirect ? target : pc_plus4;
          end
        end
        S_MEM: begin
          if (data_rvalid_i) begin
            if (opcode == OP_LOAD) res_q <= ld_val;
            else                   pc    <= pc_plus4;
          end
        end
        S_WB: begin
          if (rd_idx != 5'd0) rf[rd_idx] <= res_q;
          if ((opcode != OP_JAL) && (opcode != OP_JALR)) pc <= pc_plus4;
        end
        default: ;
      endcase
    end
  end

  // Outputs forced low while reset is asserted so they drop immediately
  assign instr_req_o  = instr_req & rst;
  assign instr_addr_o = instr_req_o ? pc : 32'd0;
  assign data_req_o   = data_req & rst;
  assign data_addr_o  = data_req_o ? res_q : 32'd0;
  assign data_we_o    = (data_req_o && (opcode == OP_STORE)) ? st_we : 4'd0;
  assign data_wdata_o = (data_req_o && (opcode == OP_STORE)) ? st_wdata : 32'd0;
  assign retire_o     = retire & rst;
  assign halt_o       = (state == S_HALT);
  assign trap_o       = (state == S_TRAP);
  assign dbg_pc_o     = pc;

endmodule

// File: tb/tb_riscv_core_mc.sv
// tb/tb_riscv_core_mc.sv - self-checking bench for riscv_core_mc
module tb_riscv_core_mc;

  logic        clk, rst;
  logic        instr_req_o, instr_rvalid_i, data_req_o, data_rvalid_i;
  logic [31:0] instr_addr_o, instr_data_i, data_addr_o, data_wdata_o, data_rdata_i, dbg_pc_o;
  logic [3:0]  data_we_o;
  logic        retire_o, halt_o, trap_o;

  riscv_core_mc dut (
    .clk(clk), .rst(rst),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_rvalid_i(instr_rvalid_i), .instr_data_i(instr_data_i),
    .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .retire_o(retire_o), .halt_o(halt_o), .trap_o(trap_o), .dbg_pc_o(dbg_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endfunction

  // Memories with programmable response delay
  logic [31:0] imem [64];
  logic [31:0] dmem [128];
  int idelay = 0, ddelay = 0, icnt = 0, dcnt = 0;

  assign instr_rvalid_i = instr_req_o && (icnt == idelay);
  assign instr_data_i   = imem[instr_addr_o[7:2]];
  assign data_rvalid_i  = data_req_o && (dcnt == ddelay);
  assign data_rdata_i   = dmem[data_addr_o[8:2]];

  always @(posedge clk) begin
    icnt <= (instr_req_o && !instr_rvalid_i) ? icnt + 1 : 0;
    dcnt <= (data_req_o && !data_rvalid_i) ? dcnt + 1 : 0;
  end

  always @(posedge clk) begin
    if (data_req_o && data_rvalid_i)
      for (int i = 0; i < 4; i++)
        if (data_we_o[i]) dmem[data_addr_o[8:2]][i*8 +: 8] = data_wdata_o[i*8 +: 8];
  end

  // Scoreboard
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } st_t;
  st_t         store_q[$];
  logic [31:0] fetch_q[$];
  logic        chk_fetch = 1'b0;
  int          retire_cnt = 0, ireq_cnt = 0, dreq_cnt = 0;
  logic        have_prev = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_we;

  always @(negedge clk) begin
    if (rst) begin
      if (retire_o) retire_cnt++;
      if (instr_req_o) ireq_cnt++;
      if (data_req_o) dreq_cnt++;
      if (chk_fetch && instr_req_o && instr_rvalid_i) begin
        if (fetch_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_extra actual=0x%08h required=none", instr_addr_o);
        end else check("fetch_addr", instr_addr_o, fetch_q.pop_front());
      end
      if (data_req_o) begin
        if (have_prev) begin
          check("data_addr_stable", data_addr_o, prev_addr);
          check("data_we_stable", 32'(data_we_o), 32'(prev_we));
          check("data_wdata_stable", data_wdata_o, prev_wdata);
        end
        prev_addr  = data_addr_o;
        prev_we    = data_we_o;
        prev_wdata = data_wdata_o;
        have_prev  = 1'b1;
        if (data_rvalid_i) begin
          have_prev = 1'b0;
          if (data_we_o != 4'd0) begin
            if (store_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL store_extra actual=0x%08h required=none", data_addr_o);
            end else begin
              st_t e;
              e = store_q.pop_front();
              check("store_addr", data_addr_o, e.addr);
              check("store_we", 32'(data_we_o), 32'(e.we));
              check("store_wdata", data_wdata_o, e.wdata);
            end
          end
        end
      end else have_prev = 1'b0;
    end
  end

  // Instruction encoders
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd5, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_op(input logic [11:0] imm, input logic [2:0] f3);
    return enc_i(imm, 5'd1, f3, 5'd5, 7'b0010011);
  endfunction

  localparam logic [31:0] ECALL = 32'h0000_0073;

  task automatic start_test(input int idl, input int ddl);
    rst = 1'b0;
    chk_fetch = 1'b0;
    fetch_q.delete();
    store_q.delete();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
    for (int i = 0; i < 128; i++) dmem[i] = 32'd0;
    idelay = idl;
    ddelay = ddl;
    retire_cnt = 0;
    ireq_cnt = 0;
    dreq_cnt = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic go();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_stop(input string nm, input int bound);
    int n;
    n = 0;
    while (!(halt_o || trap_o) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_stopped"}, 32'(halt_o || trap_o), 32'd1);
  endtask

  task automatic check_queues(input string nm);
    check({nm, "_stores_left"}, 32'(store_q.size()), 32'd0);
    check({nm, "_fetches_left"}, 32'(fetch_q.size()), 32'd0);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[20];

  initial begin
    int snap;
    vecs[0]  = '{r_op(7'h00, 3'b000), 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vecs[1]  = '{r_op(7'h20, 3'b000), 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[2]  = '{r_op(7'h00, 3'b010), 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[3]  = '{r_op(7'h00, 3'b011), 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[4]  = '{r_op(7'h00, 3'b001), 32'h0000_0001, 32'h0000_0024, 32'h0000_0010};
    vecs[5]  = '{r_op(7'h00, 3'b101), 32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
    vecs[6]  = '{r_op(7'h20, 3'b101), 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
    vecs[7]  = '{r_op(7'h00, 3'b100), 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F};
    vecs[8]  = '{r_op(7'h00, 3'b110), 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F};
    vecs[9]  = '{r_op(7'h00, 3'b111), 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000};
    vecs[10] = '{i_op(12'hFFF, 3'b000), 32'h0000_0000, 32'h0, 32'hFFFF_FFFF};
    vecs[11] = '{i_op(12'hFFF, 3'b011), 32'h0000_0005, 32'h0, 32'h0000_0001};
    vecs[12] = '{i_op(12'h41F, 3'b101), 32'h8000_0000, 32'h0, 32'hFFFF_FFFF};
    vecs[13] = '{i_op(12'hFFF, 3'b010), 32'hFFFF_FFFE, 32'h0, 32'h0000_0001};
    vecs[14] = '{{20'h12345, 5'd5, 7'b0110111}, 32'h0, 32'h0, 32'h1234_5000};
    vecs[15] = '{{20'h00001, 5'd5, 7'b0010111}, 32'h0, 32'h0, 32'h0000_1008};
    vecs[16] = '{i_op(12'h001, 3'b000), 32'hFFFF_FFFF, 32'h0, 32'h0000_0000};
    vecs[17] = '{i_op(12'hFF0, 3'b111), 32'h1234_5678, 32'h0, 32'h1234_5670};
    vecs[18] = '{i_op(12'hFFF, 3'b100), 32'h0000_FFFF, 32'h0, 32'hFFFF_0000};
    vecs[19] = '{i_op(12'h01F, 3'b101), 32'h8000_0000, 32'h0, 32'h0000_0001};

    // Reset values, then two dependent ADDIs, store and delayed load
    start_test(0, 3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {25'd0, instr_req_o, data_req_o, retire_o, halt_o, trap_o, |data_we_o}, 32'd0);
    check("rst_iaddr", instr_addr_o, 32'd0);
    check("rst_daddr", data_addr_o, 32'd0);
    check("rst_wdata", data_wdata_o, 32'd0);
    check("rst_dbg_pc", dbg_pc_o, 32'd0);
    imem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
    imem[1] = enc_i(12'hFF9, 5'd1, 3'b000, 5'd2, 7'b0010011);
    imem[2] = enc_s(12'd8, 5'd2, 5'd0, 3'b010);
    imem[3] = enc_i(12'd8, 5'd0, 3'b010, 5'd3, 7'b0000011);
    imem[4] = enc_s(12'h010, 5'd3, 5'd0, 3'b010);
    imem[5] = ECALL;
    store_q.push_back('{32'h0000_0008, 4'hF, 32'hFFFF_FFFE});
    store_q.push_back('{32'h0000_0010, 4'hF, 32'hFFFF_FFFE});
    go();
    #1;
    check("first_req", 32'(instr_req_o), 32'd1);
    check("first_addr", instr_addr_o, 32'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("two_retires_8cyc", 32'(retire_cnt), 32'd2);
    wait_stop("seqB", 200);
    check("seqB_halt", 32'(halt_o), 32'd1);
    check("seqB_retires", 32'(retire_cnt), 32'd6);
    check_queues("seqB");

    // Table of ALU / immediate vectors
    for (int v = 0; v < 20; v++) begin
      start_test(v % 2, v % 3);
      dmem[64] = vecs[v].a;
      dmem[65] = vecs[v].b;
      imem[0] = enc_i(12'h100, 5'd0, 3'b010, 5'd1, 7'b0000011);
      imem[1] = enc_i(12'h104, 5'd0, 3'b010, 5'd2, 7'b0000011);
      imem[2] = vecs[v].instr;
      imem[3] = enc_s(12'h108, 5'd5, 5'd0, 3'b010);
      imem[4] = ECALL;
      store_q.push_back('{32'h0000_0108, 4'hF, vecs[v].exp});
      go();
      wait_stop($sformatf("vec%0d", v), 300);
      check($sformatf("vec%0d_halt", v), 32'(halt_o), 32'd1);
      check($sformatf("vec%0d_retires", v), 32'(retire_cnt), 32'd5);
      check_queues($sformatf("vec%0d", v));
    end

    // Control flow with fetch stalls: JAL, taken BEQ backwards, untaken BNE
    start_test(2, 0);
    chk_fetch = 1'b1;
    imem[0]  = enc_j(21'd32, 5'd0);
    imem[8]  = enc_j(21'd16, 5'd1);
    imem[12] = enc_b(13'h1FF8, 5'd0, 5'd0, 3'b000);
    imem[10] = enc_b(13'd100, 5'd0, 5'd0, 3'b001);
    imem[11] = enc_j(21'd8, 5'd0);
    imem[13] = enc_s(12'h040, 5'd1, 5'd0, 3'b010);
    imem[14] = ECALL;
    foreach (fetch_q[i]) fetch_q.delete(i);
    fetch_q.push_back(32'h00); fetch_q.push_back(32'h20); fetch_q.push_back(32'h30);
    fetch_q.push_back(32'h28); fetch_q.push_back(32'h2C); fetch_q.push_back(32'h34);
    fetch_q.push_back(32'h38);
    store_q.push_back('{32'h0000_0040, 4'hF, 32'h0000_0024});
    go();
    wait_stop("ctrl", 400);
    check("ctrl_halt", 32'(halt_o), 32'd1);
    check("ctrl_retires", 32'(retire_cnt), 32'd7);
    check_queues("ctrl");

    // Illegal all-zero word traps; trap is sticky and requests stop
    start_test(0, 0);
    imem[0] = 32'h0000_0000;
    go();
    wait_stop("illegal", 50);
    snap = ireq_cnt;
    repeat (10) @(negedge clk);
    check("illegal_trap", 32'(trap_o), 32'd1);
    check("illegal_no_halt", 32'(halt_o), 32'd0);
    check("illegal_no_req", 32'(ireq_cnt - snap), 32'd0);
    check("illegal_retires", 32'(retire_cnt), 32'd0);
    // Asynchronous reset away from the clock edge clears the trap at once
    #2 rst = 1'b0;
    #1;
    check("async_rst_trap", 32'(trap_o), 32'd0);
    check("async_rst_pc", dbg_pc_o, 32'd0);

    // ECALL halts and retires once
    start_test(0, 0);
    imem[0] = ECALL;
    go();
    wait_stop("ecall", 50);
    repeat (5) @(negedge clk);
    check("ecall_halt", 32'(halt_o), 32'd1);
    check("ecall_no_trap", 32'(trap_o), 32'd0);
    check("ecall_retires", 32'(retire_cnt), 32'd1);
    check("ecall_reqs", 32'(ireq_cnt), 32'd1);

    // Misaligned LW traps without a bus access
    start_test(0, 0);
    imem[0] = enc_i(12'd6, 5'd0, 3'b010, 5'd3, 7'b0000011);
    go();
    wait_stop("misalign", 50);
    check("misalign_trap", 32'(trap_o), 32'd1);
    check("misalign_no_dreq", 32'(dreq_cnt), 32'd0);

    // Sub-word accesses
    start_test(0, 1);
    imem[0] = enc_i(12'hFFE, 5'd0, 3'b000, 5'd2, 7'b0010011);
    imem[1] = enc_s(12'd3, 5'd2, 5'd0, 3'b000);
`ifdef RISCV_SUBWORD_EN
    imem[2] = enc_i(12'd3, 5'd0, 3'b000, 5'd4, 7'b0000011);
    imem[3] = enc_s(12'h010, 5'd4, 5'd0, 3'b010);
    imem[4] = enc_i(12'd1, 5'd0, 3'b001, 5'd5, 7'b0000011);
    store_q.push_back('{32'h0000_0003, 4'b1000, 32'hFE00_0000});
    store_q.push_back('{32'h0000_0010, 4'hF, 32'hFFFF_FFFE});
    go();
    wait_stop("subword", 200);
    check("subword_lh_trap", 32'(trap_o), 32'd1);
    check("subword_retires", 32'(retire_cnt), 32'd4);
    check("subword_mem0", dmem[0], 32'hFE00_0000);
    check_queues("subword");
`else
    go();
    wait_stop("sb_disabled", 100);
    check("sb_disabled_trap", 32'(trap_o), 32'd1);
    check("sb_disabled_no_dreq", 32'(dreq_cnt), 32'd0);
    check("sb_disabled_retires", 32'(retire_cnt), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
